// File: rtl/lif_array_scheduler.sv
// ============================================================================
// Module      : lif_array_scheduler
// Description : One time-multiplexed leaky-integrate-and-fire datapath swept
//               across N_NEURONS virtual neurons, with indexed spike events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_array_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = 3,
  parameter int LEAK_SHIFT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic [15:0]      threshold_i,
  input  logic [7:0]       refractory_period_i,
  input  logic             cur_we_i,
  input  logic [IDX_W-1:0] cur_idx_i,
  input  logic [15:0]      cur_data_i,
  output logic             spk_valid_o,
  output logic [IDX_W-1:0] spk_idx_o,
  input  logic             spk_ready_i,
  output logic             busy_o,
  output logic             step_done_o,
  output logic             overrun_o,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [15:0]      rd_potential_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;
  logic             step_done_q;
  logic             overrun_q;
  logic             spk_valid_q;
  logic [IDX_W-1:0] spk_idx_q;
  logic [15:0]      rd_potential_q;

  logic [15:0] pot_q [N_NEURONS];
  logic [7:0]  ref_q [N_NEURONS];
  logic [15:0] cur_q [N_NEURONS];

  logic [15:0] pot_cur_d;
  logic [15:0] cur_cur_d;
  logic [7:0]  ref_cur_d;
  logic [16:0] sum_d;
  logic [15:0] pot_next_d;
  logic        refractory_d;
  logic        spike_d;
  logic        process_d;
  logic        last_d;

  assign pot_cur_d    = pot_q[ptr_q];
  assign cur_cur_d    = cur_q[ptr_q];
  assign ref_cur_d    = ref_q[ptr_q];
  // v - (v >> LEAK_SHIFT) never goes negative, so 17 bits hold the full sum.
  assign sum_d        = {1'b0, pot_cur_d} - {1'b0, (pot_cur_d >> LEAK_SHIFT)} + {1'b0, cur_cur_d};
  assign pot_next_d   = sum_d[16] ? 16'hFFFF : sum_d[15:0];
  assign refractory_d = (ref_cur_d != 8'd0);
  assign spike_d      = !refractory_d && (pot_next_d >= threshold_i);
  assign process_d    = (state_q == S_RUN) && (!spk_valid_q || spk_ready_i);
  assign last_d       = (ptr_q == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i] <= '0;
        ref_q[i] <= '0;
        cur_q[i] <= '0;
      end
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      busy_q         <= 1'b0;
      step_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      spk_valid_q    <= 1'b0;
      spk_idx_q      <= '0;
      rd_potential_q <= '0;
    end else begin
      step_done_q    <= 1'b0;
      rd_potential_q <= pot_q[rd_idx_i];
      // busy stays up through the step_done cycle so a tick there counts as overrun.
      if (step_done_q) busy_q <= 1'b0;
      if (tick_i && busy_q) overrun_q <= 1'b1;
      if (cur_we_i) cur_q[cur_idx_i] <= cur_data_i;
      if (spk_valid_q && spk_ready_i) spk_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tick_i && !busy_q) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (process_d) begin
            if (refractory_d) begin
              ref_q[ptr_q] <= ref_cur_d - 8'd1;
            end else if (spike_d) begin
              pot_q[ptr_q] <= '0;
              ref_q[ptr_q] <= refractory_period_i;
              spk_valid_q  <= 1'b1;
              spk_idx_q    <= ptr_q;
            end else begin
              pot_q[ptr_q] <= pot_next_d;
            end
            if (last_d) begin
              state_q     <= S_IDLE;
              step_done_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spk_valid_o    = spk_valid_q;
  assign spk_idx_o      = spk_idx_q;
  assign busy_o         = busy_q;
  assign step_done_o    = step_done_q;
  assign overrun_o      = overrun_q;
  assign rd_potential_o = rd_potential_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_array_scheduler.sv
// ============================================================================
// Module      : tb_lif_array_scheduler
// Description : Directed and randomized checks of lif_array_scheduler against
//               a timestep-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lif_array_scheduler;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          cur_we = 1'b0;
  logic [15:0]   threshold = 16'd0;
  logic [7:0]    refractory_period = 8'd0;
  logic [IW-1:0] cur_idx = '0;
  logic [15:0]   cur_data = 16'd0;
  logic [IW-1:0] rd_idx = '0;
  logic          spk_ready;
  logic          spk_valid;
  logic [IW-1:0] spk_idx;
  logic          busy;
  logic          step_done;
  logic          overrun;
  logic [15:0]   rd_potential;

  logic rdy_cmd  = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_rdy  = 1'b1;
  assign spk_ready = rand_rdy ? rnd_rdy : rdy_cmd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: potential, refractory count, current per neuron.
  int mv [N];
  int mr [N];
  int mc [N];
  int m_th;
  int m_rp;
  int exp_q[$];
  int got_q[$];
  int last_q[$];

  always #5 clk = ~clk;

  lif_array_scheduler #(.N_NEURONS(N), .IDX_W(IW), .LEAK_SHIFT(4)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .tick_i              (tick),
    .threshold_i         (threshold),
    .refractory_period_i (refractory_period),
    .cur_we_i            (cur_we),
    .cur_idx_i           (cur_idx),
    .cur_data_i          (cur_data),
    .spk_valid_o         (spk_valid),
    .spk_idx_o           (spk_idx),
    .spk_ready_i         (spk_ready),
    .busy_o              (busy),
    .step_done_o         (step_done),
    .overrun_o           (overrun),
    .rd_idx_i            (rd_idx),
    .rd_potential_o      (rd_potential)
  );

  always @(posedge clk) begin
    if (!reset && spk_valid && spk_ready) got_q.push_back(int'(spk_idx));
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mr[i] = 0;
      mc[i] = 0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // One whole timestep, neurons in index order.
  task automatic model_step();
    int vn;
    for (int i = 0; i < N; i++) begin
      if (mr[i] > 0) begin
        mr[i] = mr[i] - 1;
      end else begin
        vn = mv[i] + mc[i] - (mv[i] / 16);
        if (vn > 65535) vn = 65535;
        if (vn >= m_th) begin
          mv[i] = 0;
          mr[i] = m_rp;
          exp_q.push_back(i);
        end else begin
          mv[i] = vn;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0;
    cur_we = 1'b0;
    rdy_cmd = 1'b1;
    rand_rdy = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic set_cfg(input int th, input int rp);
    threshold = th[15:0];
    refractory_period = rp[7:0];
    m_th = th;
    m_rp = rp;
  endtask

  task automatic write_cur(input int idx, input int val);
    cur_we = 1'b1;
    cur_idx = idx[IW-1:0];
    cur_data = val[15:0];
    step();
    cur_we = 1'b0;
    mc[idx] = val;
  endtask

  task automatic start_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!step_done && lat < 300) begin
      step();
      lat++;
    end
    chk("step_done_seen", step_done, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    step();
    while (spk_valid && k < 300) begin
      step();
      k++;
    end
    chk("drained", spk_valid, 0);
    chk("idle_after_sweep", busy, 0);
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_idx%0d", tag, i), got_q[i], exp_q[i]);
    last_q = got_q;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_step(input bit chk_lat);
    int lat;
    start_tick();
    wait_done(lat);
    if (chk_lat) chk("latency", lat, N + 1);
    drain();
    model_step();
    compare_events("events");
  endtask

  task automatic read_pot(input int idx, output logic [15:0] val);
    rd_idx = idx[IW-1:0];
    step();
    val = rd_potential;
  endtask

  task automatic check_pots(input string tag);
    logic [15:0] v;
    for (int i = 0; i < N; i++) begin
      read_pot(i, v);
      chk($sformatf("%s_pot%0d", tag, i), v, mv[i]);
    end
  endtask

  initial begin
    int leak_tab [5] = '{100, 194, 282, 365, 443};
    int spk_tab  [6] = '{600, 0, 0, 0, 600, 0};
    int cnt;
    int lat;
    logic [15:0] v;

    // Reset state
    do_reset();
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_spk_idx", spk_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_potential", rd_potential, 0);

    // Leak and integrate
    set_cfg(1000, 0);
    write_cur(0, 100);
    for (int t = 0; t < 5; t++) begin
      run_step(1);
      read_pot(0, v);
      chk($sformatf("leak_ts%0d", t + 1), v, leak_tab[t]);
      chk($sformatf("leak_model_ts%0d", t + 1), v, mv[0]);
    end

    // Spike and refractory
    do_reset();
    set_cfg(1000, 2);
    write_cur(3, 600);
    for (int t = 0; t < 6; t++) begin
      run_step(1);
      chk($sformatf("refr_spikes_ts%0d", t + 1), last_q.size(), (t == 1 || t == 5) ? 1 : 0);
      read_pot(3, v);
      chk($sformatf("refr_pot_ts%0d", t + 1), v, spk_tab[t]);
    end

    // Backpressure: first event must hold while stalled
    do_reset();
    set_cfg(1000, 0);
    for (int i = 0; i < N; i++) write_cur(i, 2000);
    rdy_cmd = 1'b0;
    start_tick();
    step();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_held", spk_valid, 1);
      chk("bp_idx_held", spk_idx, 0);
      chk("bp_busy_held", busy, 1);
      step();
    end
    rdy_cmd = 1'b1;
    wait_done(lat);
    drain();
    model_step();
    compare_events("bp_events");
    check_pots("bp");

    // Saturation without wrap
    do_reset();
    set_cfg(16'hFFFF, 0);
    write_cur(1, 16'hFFFF);
    write_cur(2, 16'h9000);
    run_step(1);
    chk("sat_ts1_count", last_q.size(), 1);
    if (last_q.size() > 0) chk("sat_ts1_idx", last_q[0], 1);
    check_pots("sat1");
    run_step(1);
    chk("sat_ts2_count", last_q.size(), 2);
    check_pots("sat2");

    // Overrun: second tick three cycles into a sweep
    do_reset();
    set_cfg(60000, 0);
    start_tick();
    step();
    step();
    start_tick();
    chk("ovr_set", overrun, 1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (step_done) cnt++;
      step();
    end
    chk("ovr_one_sweep", cnt, 1);
    chk("ovr_sticky", overrun, 1);

    // Overrun: tick coinciding with step_done
    do_reset();
    set_cfg(60000, 0);
    start_tick();
    wait_done(lat);
    chk("ovr2_before", overrun, 0);
    start_tick();
    chk("ovr2_set", overrun, 1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (step_done) cnt++;
      step();
    end
    chk("ovr2_no_sweep", cnt, 0);
    chk("ovr2_idle", busy, 0);

    // Reset in the middle of a sweep with an event pending
    do_reset();
    set_cfg(1000, 0);
    for (int i = 0; i < N; i++) write_cur(i, 2000);
    rdy_cmd = 1'b0;
    start_tick();
    step();
    step();
    chk("mid_pending", spk_valid, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", spk_valid, 0);
    chk("mid_rst_idx", spk_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", step_done, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_rdpot", rd_potential, 0);
    reset = 1'b0;
    model_clear();
    rdy_cmd = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (step_done || spk_valid) cnt++;
      step();
    end
    chk("mid_no_activity", cnt, 0);
    chk("mid_no_events", got_q.size(), 0);
    check_pots("mid");

    // Write to the neuron being processed in the same cycle
    do_reset();
    set_cfg(60000, 0);
    write_cur(4, 100);
    start_tick();
    for (int c = 0; c < 4; c++) step();
    cur_we = 1'b1;
    cur_idx = 3'd4;
    cur_data = 16'd500;
    step();
    cur_we = 1'b0;
    wait_done(lat);
    drain();
    model_step();
    mc[4] = 500;
    compare_events("cw_events");
    read_pot(4, v);
    chk("cw_old_current", v, 100);
    run_step(1);
    read_pot(4, v);
    chk("cw_new_current", v, 594);

    // Randomized timesteps with random backpressure
    do_reset();
    set_cfg(1500, 1);
    rand_rdy = 1'b1;
    for (int s = 0; s < 25; s++) begin
      if (s % 4 == 0) set_cfg($urandom_range(200, 4000), $urandom_range(0, 3));
      if (s == 10) set_cfg(0, 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) write_cur(i, $urandom_range(0, 1500));
      end
      run_step(0);
      check_pots($sformatf("rnd%0d", s));
    end
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lif_array_scheduler.md
Name: lif_array_scheduler

Overview:
- Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons.
- Per-neuron membrane potential, refractory count and input current are held in internal register files.
- On each timestep tick the block sweeps neurons 0..N_NEURONS-1, one neuron per cycle.
- Each spike is emitted as an indexed event over a valid/ready stream to the downstream synapse/router logic.

Parameters:
- N_NEURONS, 8, number of virtual neurons (2..256).
- IDX_W, 3, index width; must equal clog2(N_NEURONS).
- LEAK_SHIFT, 4, leak term is potential >> LEAK_SHIFT (1..15).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle pulse: start a timestep sweep
- threshold  in  16  spike threshold, global, sampled per neuron update
- refractory_period  in  8  cycles-of-timesteps loaded on spike, global
- cur_we  in  1  write enable for current register file
- cur_idx  in  IDX_W  neuron index for current write
- cur_data  in  16  unsigned input current value
- spk_valid  out  1  spike event valid
- spk_idx  out  IDX_W  index of spiking neuron
- spk_ready  in  1  downstream accepts event
- busy  out  1  sweep in progress
- step_done  out  1  one-cycle pulse, sweep finished
- overrun  out  1  sticky: tick arrived while busy
- rd_idx  in  IDX_W  potential readback index
- rd_potential  out  16  registered potential of rd_idx, 1-cycle latency

Behaviour:
- Reset (synchronous):
  - all potentials, refractory counts and currents := 0.
  - spk_valid, busy, step_done, overrun, rd_potential := 0; spk_idx := 0; FSM := IDLE.
  - Reset mid-sweep aborts the sweep with no further events; a pending spike event is dropped.
- FSM states:
  - IDLE: on tick, go to RUN with ptr := 0 and busy := 1.
  - RUN: process neuron ptr when the output slot is free, i.e. !spk_valid || spk_ready. Otherwise hold ptr (stall) and commit no state.
  - After processing ptr = N_NEURONS-1, go to IDLE in the next cycle: busy := 0, step_done := 1 for exactly one cycle.
  - Sweep latency with no stalls: tick at cycle T gives step_done high at cycle T+N_NEURONS+1.
- Per-neuron update (committed in the cycle ptr is processed):
  - If ref[ptr] > 0: ref := ref - 1, potential held, no spike, current ignored.
  - Otherwise compute v_next = v + cur - (v >> LEAK_SHIFT) in 17 bits, saturating at 16'hFFFF.
  - If v_next >= threshold: potential := 0, ref := refractory_period, and load the spike event (spk_valid := 1, spk_idx := ptr).
  - Else potential := v_next.
- threshold = 0: every non-refractory neuron spikes every timestep.
- refractory_period = 0: a neuron may spike on consecutive timesteps.
- Spike stream:
  - One-entry output register.
  - spk_valid and spk_idx stay stable while spk_valid && !spk_ready.
  - Transfer happens on spk_valid && spk_ready.
  - Drain and reload in the same cycle is allowed, giving back-to-back events with no bubble.
  - The last event of a sweep may still be pending after step_done.
- Current writes:
  - Accepted in any state.
  - A write to the neuron being processed in the same cycle takes effect on the next timestep; the update uses the old value.
  - Currents persist across timesteps until rewritten.
- tick while busy:
  - Ignored and sets overrun := 1.
  - overrun clears only on reset.
  - A tick in the same cycle as step_done is also overrun, because busy is still 1 in that cycle.
- rd_potential = potential[rd_idx] registered every cycle; it reflects committed updates with 1-cycle delay.

Test Plan:
- Leak/integrate: N=8, LEAK_SHIFT=4, threshold=1000, cur[0]=100, spk_ready=1, 5 ticks -> rd_potential(0) = 100, 194, 282, 365, 443; no spikes; step_done 9 cycles after each tick.
- Spike/refractory: cur[3]=600, threshold=1000, refractory_period=2 -> spike idx 3 on timestep 2, potential 0. Timesteps 3–4: no integration. Timestep 5: potential 600. Timestep 6: spike again.
- Backpressure: all cur=2000, threshold=1000, spk_ready low for 10 cycles then high -> spk_idx 0 held stable while stalled, then events 0..7 in order; no event lost or duplicated; busy held until ptr 7 processed.
- Saturation: cur[1]=16'hFFFF, threshold=16'hFFFF -> v_next saturates at 16'hFFFF, spike on timestep 1, no wrap to a small value.
- Overrun/reset: tick twice 3 cycles apart -> overrun=1 and only one sweep occurs. Reset asserted mid-sweep with spk_valid=1 -> next cycle all outputs 0 and all potentials read 0.
- Concurrent write: cur_we to ptr's index in its processing cycle -> old current used this timestep, new value used on next timestep.
